// File: rtl/dsmod_feeder.sv
// Sample-rate feeder for a delta-sigma modulator: start/stop sequencing, one
// sample per oversampling period over valid/ready, and a linear mute-gain ramp.
//
// state     | meaning
// IDLE      | modulator held cleared, gain 0, no sample requests
// RAMP_UP   | gain steps +1 per sample period toward full scale
// RUN       | full gain (2^gw), samples passed straight through
// RAMP_DOWN | gain steps -1 per sample period toward 0
module dsmod_feeder #(
   parameter int n   = 16,
   parameter int osr = 64,
   parameter int gw  = 8
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                en,
   input  logic signed [n-1:0] in,
   input  logic                in_valid,
   output logic                in_ready,
   output logic signed [n-1:0] mod_in,
   output logic                mod_clr,
   output logic                busy,
   output logic                running,
   output logic                underrun
);

   localparam int dw = (osr > 2) ? $clog2(osr) : 1;
   localparam logic [dw-1:0] div_last = dw'(osr - 1);
   localparam logic [gw:0]   g_full   = {1'b1, {gw{1'b0}}};
   localparam logic [gw:0]   g_top    = {1'b0, {gw{1'b1}}};
   localparam logic [gw:0]   g_one    = (gw+1)'(1);

   typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;

   state_t                    state, state_next;
   logic [dw-1:0]             div;
   logic [gw:0]               g, g_next;
   logic signed [n-1:0]       sample_r;
   logic                      strobe;
   logic signed [n+gw+1:0]    sample_x, g_x;

   assign sample_x = {{(gw+2){sample_r[n-1]}}, sample_r};
   assign g_x      = signed'({{(n+1){1'b0}}, g});

   always_comb begin
      state_next = state;
      g_next     = g;
      strobe     = (div == div_last) && (state != IDLE);
      case (state)
         IDLE: begin
            g_next = '0;
            if (en) state_next = RAMP_UP;
         end
         RAMP_UP: begin
            // g can sit at full scale here after a quick RUN->down->up bounce
            if (strobe && g != g_full) g_next = g + g_one;
            if (!en)
               state_next = RAMP_DOWN;
            else if (g == g_full || (strobe && g == g_top))
               state_next = RUN;
         end
         RUN: begin
            g_next = g_full;
            if (!en) state_next = RAMP_DOWN;
         end
         RAMP_DOWN: begin
            if (strobe && g != '0) g_next = g - g_one;
            if (en)
               state_next = RAMP_UP;
            else if (g == '0 || (strobe && g == g_one))
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      in_ready = strobe;
      mod_clr  = (state == IDLE);
      busy     = (state != IDLE);
      running  = (state == RUN);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= IDLE;
         div      <= '0;
         g        <= '0;
         sample_r <= '0;
         mod_in   <= '0;
         underrun <= 1'b0;
      end else begin
         state <= state_next;
         g     <= g_next;
         if (state == IDLE || state_next == IDLE)
            div <= '0;
         else if (div == div_last)
            div <= '0;
         else
            div <= div + dw'(1);
         if (strobe && in_valid) sample_r <= in;
         underrun <= strobe && !in_valid;
         if (state == IDLE)
            mod_in <= '0;
         else
            mod_in <= n'((sample_x * g_x) >>> gw);
      end
   end

endmodule

// File: tb/tb_dsmod_feeder.sv
// Bench for dsmod_feeder (n=16, osr=4, gw=2): per-sample-period vector table
// with a scoreboard queue, plus hand sequences for startup timing and reset.
module tb_dsmod_feeder;

   localparam int N   = 16;
   localparam int OSR = 4;
   localparam int GW  = 2;

   logic                clk = 1'b0;
   logic                clr, en, in_valid;
   logic signed [N-1:0] din;
   logic                in_ready, mod_clr, busy, running, underrun;
   logic signed [N-1:0] mod_in;

   always #5 clk = ~clk;

   dsmod_feeder #(.n(N), .osr(OSR), .gw(GW)) dut (
      .clk      (clk),
      .clr      (clr),
      .en       (en),
      .in       (din),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mod_in   (mod_in),
      .mod_clr  (mod_clr),
      .busy     (busy),
      .running  (running),
      .underrun (underrun)
   );

   typedef struct {
      logic                en_v;
      logic signed [N-1:0] smp;
      logic                vld;
      logic signed [N-1:0] exp_mod;
      logic                exp_run;
      logic                exp_busy;
      logic                exp_und;
   } vec_t;

   vec_t                vecs [0:27];
   logic signed [N-1:0] sb_q [$];
   int                  errors = 0;
   int                  checks = 0;

   function automatic vec_t mk(input bit e, input int s, input bit vl, input int m,
                               input bit r, input bit b, input bit u);
      vec_t v;
      v.en_v = e; v.smp = N'(s); v.vld = vl; v.exp_mod = N'(m);
      v.exp_run = r; v.exp_busy = b; v.exp_und = u;
      return v;
   endfunction

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_mod_in"},   mod_in,   0);
      check({tag, "_underrun"}, underrun, 0);
      check({tag, "_mod_clr"},  mod_clr,  1);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_busy"},     busy,     0);
      check({tag, "_running"},  running,  0);
   endtask

   // Called one cycle before the edge that samples en=1 in IDLE.
   task automatic check_first_strobe(input string tag);
      int cnt = 0;
      tick();
      check({tag, "_mod_clr_fall"}, mod_clr, 0);
      check({tag, "_busy_rise"},    busy,    1);
      while (in_ready !== 1'b1 && cnt < 2*OSR) begin
         tick();
         cnt++;
      end
      check({tag, "_first_strobe_delay"}, cnt, OSR-1);
   endtask

   task automatic apply_vec(input int i);
      vec_t                v;
      logic signed [N-1:0] exp_m;
      int                  w = 0;
      v = vecs[i];
      en = v.en_v; din = v.smp; in_valid = v.vld;
      while (in_ready !== 1'b1 && w < 2*OSR) begin
         tick();
         w++;
      end
      if (in_ready !== 1'b1) begin
         errors++; checks++;
         $display("FAIL strobe_timeout vec %0d: in_ready=%b expected 1", i, in_ready);
         return;
      end
      sb_q.push_back(v.exp_mod);
      tick();
      check($sformatf("v%0d_running", i),  running,  v.exp_run);
      check($sformatf("v%0d_busy", i),     busy,     v.exp_busy);
      check($sformatf("v%0d_mod_clr", i),  mod_clr,  !v.exp_busy);
      check($sformatf("v%0d_underrun", i), underrun, v.exp_und);
      check($sformatf("v%0d_ready_pulse", i), in_ready, 0);
      tick();
      if (sb_q.size() == 0) begin
         errors++; checks++;
         $display("FAIL v%0d_scoreboard: queue empty, expected one entry", i);
      end else begin
         exp_m = sb_q.pop_front();
         check($sformatf("v%0d_mod_in", i), mod_in, exp_m);
      end
      check($sformatf("v%0d_underrun_end", i), underrun, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      //              en  in      vld mod     run busy und
      vecs[0]  = mk(1,  1000,   1,  250,    0,  1,   0);
      vecs[1]  = mk(1,  1000,   1,  500,    0,  1,   0);
      vecs[2]  = mk(1,  1000,   1,  750,    0,  1,   0);
      vecs[3]  = mk(1,  1000,   1,  1000,   1,  1,   0);
      vecs[4]  = mk(1,  -32768, 1,  -32768, 1,  1,   0);
      vecs[5]  = mk(1,  32767,  1,  32767,  1,  1,   0);
      vecs[6]  = mk(1,  1000,   1,  1000,   1,  1,   0);
      vecs[7]  = mk(1,  5,      0,  1000,   1,  1,   1);
      vecs[8]  = mk(1,  -4,     1,  -4,     1,  1,   0);
      vecs[9]  = mk(0,  1000,   1,  750,    0,  1,   0);
      vecs[10] = mk(0,  1000,   1,  500,    0,  1,   0);
      vecs[11] = mk(0,  1000,   1,  250,    0,  1,   0);
      vecs[12] = mk(0,  1000,   1,  0,      0,  0,   0);
      vecs[13] = mk(1,  1000,   1,  250,    0,  1,   0);
      vecs[14] = mk(1,  1000,   1,  500,    0,  1,   0);
      vecs[15] = mk(0,  1000,   1,  250,    0,  1,   0);
      vecs[16] = mk(1,  1000,   1,  500,    0,  1,   0);
      vecs[17] = mk(1,  1000,   1,  750,    0,  1,   0);
      vecs[18] = mk(1,  1000,   1,  1000,   1,  1,   0);
      vecs[19] = mk(0,  1000,   1,  750,    0,  1,   0);
      vecs[20] = mk(0,  1000,   1,  500,    0,  1,   0);
      vecs[21] = mk(0,  -1001,  1,  -251,   0,  1,   0);
      vecs[22] = mk(0,  0,      1,  0,      0,  0,   0);
      vecs[23] = mk(1,  1000,   1,  250,    0,  1,   0);
      vecs[24] = mk(1,  1000,   1,  500,    0,  1,   0);
      vecs[25] = mk(1,  1000,   1,  750,    0,  1,   0);
      vecs[26] = mk(1,  1000,   1,  1000,   1,  1,   0);
      vecs[27] = mk(1,  1000,   1,  250,    0,  1,   0);

      clr = 1'b1; en = 1'b0; din = '0; in_valid = 1'b0;
      tick(); tick();
      check_reset_vals("por");
      clr = 1'b0;
      tick();
      check_reset_vals("idle");

      // startup, RUN extremes, underrun, shutdown
      en = 1'b1; din = 16'sd1000; in_valid = 1'b1;
      check_first_strobe("start");
      for (int i = 0; i <= 12; i++) apply_vec(i);
      for (int k = 0; k < 2*OSR; k++) begin
         tick();
         check("idle_mod_in", mod_in, 0);
         check("idle_in_ready", in_ready, 0);
      end

      // reversal mid-ramp, then ramp down through a rounding case
      for (int i = 13; i <= 22; i++) apply_vec(i);

      // reset while running with en held high
      for (int i = 23; i <= 26; i++) apply_vec(i);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check_reset_vals("clr_run");
      check_first_strobe("restart");
      apply_vec(27);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dsmod_feeder.md
# dsmod_feeder

Sample-rate controller for a delta-sigma modulator. It runs a start/stop state machine around the modulator and pulls one sample per oversampling period from an upstream source over a valid/ready handshake. Each sample is scaled by a linear mute gain, so start and stop ramp smoothly instead of stepping. Its outputs drive the modulator's data input and clear input directly, and the feeder sits between the audio/sample source and the modulator.

## Interface
- n, 16: sample width (signed), equal to the modulator input width.
- osr, 64: clk cycles per sample (oversampling ratio), must be >= 2.
- gw, 8: gain fraction bits; a full ramp spans 2^gw samples.

- clk  in  1  sampling clock, shared with the modulator.
- clr  in  1  reset; synchronous, active-high.
- en  in  1  run request; level-sensitive.
- in  in  n  signed sample from upstream.
- in_valid  in  1  `in` holds a valid sample.
- in_ready  out  1  sample request strobe; one cycle per sample period.
- mod_in  out  n  signed, registered; connects to the modulator `in`.
- mod_clr  out  1  holds the modulator cleared; connects to the modulator `clr`.
- busy  out  1  state != IDLE.
- running  out  1  state == RUN (full gain).
- underrun  out  1  one-cycle pulse when a sample strobe found `in_valid` low.

## Operation
- Registers:
  - state: IDLE, RAMP_UP, RUN, RAMP_DOWN.
  - div: 0..osr-1.
  - g: gw+1 bits, range 0..2^gw.
  - sample_r: n bits.
  - mod_in, underrun.
- Sample strobe:
  - strobe = (div == osr-1) && state != IDLE.
  - in_ready = strobe, combinational from registers.
  - div increments every non-IDLE cycle and wraps osr-1 -> 0.
  - div is held at 0 in IDLE.
- Handshake:
  - At a strobe edge with in_valid=1, sample_r <= in.
  - At a strobe edge with in_valid=0, sample_r holds its value and underrun <= 1 for the next cycle. Otherwise underrun <= 0.
  - Upstream must not rely on in_ready before asserting in_valid.
- Gain, updated only on strobe edges:
  - RAMP_UP: g <= g+1.
  - RAMP_DOWN: g <= g-1.
  - RUN: g == 2^gw.
  - IDLE: g == 0.
- Datapath:
  - Every cycle, mod_in <= (sample_r * g) >>> gw.
  - Product is signed, n+gw+2 bits wide.
  - The shift is arithmetic, so results round toward −inf.
  - Truncation to n bits never overflows because g <= 2^gw.
  - In IDLE, mod_in <= 0.
- mod_clr = (state == IDLE), combinational from the state register.
- FSM transitions; en is evaluated every cycle, not only on strobes:
  - IDLE: en=1 -> RAMP_UP.
  - RAMP_UP:
    - en=0 -> RAMP_DOWN; g continues from its current value.
    - Otherwise, a strobe with g == 2^gw−1 -> RUN (g becomes 2^gw).
  - RUN: en=0 -> RAMP_DOWN.
  - RAMP_DOWN:
    - en=1 -> RAMP_UP.
    - Otherwise, a strobe with g == 1 -> IDLE (g becomes 0).
    - Also -> IDLE if g is already 0.
  - If en changes on a strobe edge, that strobe's sample and gain step use the old state's rule, and the state changes on the same edge.
- Samples are consumed in both ramp states as well as RUN.

## Timing
- Reset (clr=1 at an edge), effective after that edge:
  - state=IDLE, div=0, g=0, sample_r=0.
  - mod_in=0, underrun=0.
  - mod_clr=1, in_ready=0, busy=0, running=0.
  - clr overrides en and any strobe on the same edge.
- Start timing, with en sampled high at edge E0:
  - mod_clr falls after E0.
  - The first in_ready falls in the cycle before edge E0+osr.
  - Further strobes follow every osr cycles.
- Latency: a sample accepted at edge E appears on mod_in after edge E+1, scaled by the g value updated at E.
- Full ramp up: 2^gw strobes after leaving IDLE. Full ramp down: 2^gw strobes from RUN.
- IDLE is entered on the strobe edge where g reaches 0. mod_in is forced to 0 on the following edge, while mod_clr is already high.

## Test plan
All scenarios use n=16, osr=4, gw=2, unless stated otherwise.

1. Startup ramp:
   - Stimulus: clr, then en=1, in=1000, in_valid=1.
   - Required: in_ready high every 4th cycle; mod_in = 250, 500, 750, 1000; running rises on the 4th strobe edge; mod_clr=0 from the first non-IDLE cycle.
2. Shutdown:
   - Stimulus: from RUN with in=1000, drop en.
   - Required: mod_in = 750, 500, 250, 0; busy falls and mod_clr rises on the 4th strobe edge; mod_in=0 afterwards.
3. Underrun:
   - Stimulus: in RUN, in_valid=0 for one strobe.
   - Required: underrun pulses for exactly 1 cycle; mod_in holds the previous sample.
4. Reversal:
   - Stimulus: drop en when g=2 during RAMP_UP, then raise en after one strobe.
   - Required: g sequence 2 -> 1 -> 2 -> 3 -> 4; no IDLE entry; mod_clr stays 0.
5. Rounding and extremes:
   - Stimulus 1: in=−1001 at g=1. Required: mod_in=−251.
   - Stimulus 2: in=−32768 and in=32767 in RUN. Required: mod_in passes both values exactly.
6. Reset mid-RUN:
   - Stimulus: assert clr for 1 cycle while en=1.
   - Required: the next cycle shows all Timing reset values. Because en=1, the FSM re-enters RAMP_UP one edge later with g=0.
